// File: rtl/car_sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_sensor_pkg
// Description : Shared definitions for the car sensor-pattern generator:
//               FSM state encoding, beam patterns per phase and the
//               direction encoding, plus a pattern lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package car_sensor_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PH1  = 2'd1;
    localparam logic [1:0] ST_PH2  = 2'd2;
    localparam logic [1:0] ST_PH3  = 2'd3;

    // Direction encoding of the dir input
    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // {a,b} per phase; consecutive phases differ in one bit only
    localparam logic [1:0] ENTRY_PAT [1:3] = '{2'b10, 2'b11, 2'b01};
    localparam logic [1:0] EXIT_PAT  [1:3] = '{2'b01, 2'b11, 2'b10};

    // {a,b} for a given direction and state; IDLE is always 00
    function automatic logic [1:0] phase_pat(input logic dir_i, input logic [1:0] st);
        logic [1:0] pat;
        pat = 2'b00;
        case (st)
            ST_PH1:  pat = (dir_i == DIR_EXIT) ? EXIT_PAT[1] : ENTRY_PAT[1];
            ST_PH2:  pat = (dir_i == DIR_EXIT) ? EXIT_PAT[2] : ENTRY_PAT[2];
            ST_PH3:  pat = (dir_i == DIR_EXIT) ? EXIT_PAT[3] : ENTRY_PAT[3];
            default: pat = 2'b00;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter holding the remaining dwell of the
//               current phase. Counts down to zero and stops there.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               load     - load load_val on the next edge (wins over count)
//               load_val - value to load
//               val      - current count
//               zero     - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] val,
    output logic             zero
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
        end else if (load) begin
            r_val <= load_val;
        end else if (r_val != '0) begin
            r_val <= r_val - c_one;
        end
    end

    assign val  = r_val;
    assign zero = (r_val == '0);

endmodule
`default_nettype wire

// File: rtl/car_sensor_gen.sv
`default_nettype none
// ============================================================================
// Module      : car_sensor_gen
// Description : Drives the a/b beam-sensor lines through one complete car
//               entry or exit sequence on request, holding each phase for a
//               programmable number of cycles.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset
//               start - request one car pass (sampled in IDLE only)
//               dir   - 0 entry, 1 exit (latched with start)
//               dwell - cycles per phase, 0 behaves as 1 (latched with start)
//               abort - cancel the sequence in progress
//               a, b  - outer / inner beam sensor lines (registered)
//               busy  - sequence in progress (registered)
//               done  - one-cycle pulse on normal completion (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module car_sensor_gen
    import car_sensor_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done
);

    localparam logic [DWELL_W-1:0] c_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic               r_dir;
    logic [DWELL_W-1:0] r_d;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic [1:0]         w_next_phase;
    logic               w_load;
    logic [DWELL_W-1:0] w_load_val;
    logic               w_zero;
    logic [DWELL_W-1:0] w_timer_val;

    // Timer reloads on start and on each phase advance; in between it
    // counts down by itself, so the FSM only has to watch the zero flag.
    always_comb begin
        w_dwell_eff  = (dwell == '0) ? c_one : dwell;
        w_next_phase = r_state + 2'd1;
        w_load       = 1'b0;
        w_load_val   = '0;
        if (r_state == ST_IDLE) begin
            if (start) begin
                w_load     = 1'b1;
                w_load_val = w_dwell_eff - c_one;
            end
        end else if (!abort && w_zero && (r_state != ST_PH3)) begin
            w_load     = 1'b1;
            w_load_val = r_d - c_one;
        end
    end

    phase_timer #(
        .WIDTH (DWELL_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .val      (w_timer_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_ENTRY;
            r_d     <= c_one;
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_dir   <= dir;
                    r_d     <= w_dwell_eff;
                    r_state <= ST_PH1;
                    {a, b}  <= phase_pat(dir, ST_PH1);
                    busy    <= 1'b1;
                end
            end else if (abort) begin
                // Abort wins over timer expiry; both lines may drop at once
                r_state <= ST_IDLE;
                {a, b}  <= 2'b00;
                busy    <= 1'b0;
            end else if (w_zero) begin
                if (r_state == ST_PH3) begin
                    r_state <= ST_IDLE;
                    {a, b}  <= 2'b00;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    r_state <= w_next_phase;
                    {a, b}  <= phase_pat(r_dir, w_next_phase);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/car_sensor_gen.md
# car_sensor_gen

Sensor-pattern generator for the parking-lot gate: on command it drives the two beam-sensor lines `a`/`b` through a complete entry or exit sequence with programmable dwell per phase. It is the transmit end of the `a`/`b` sensor interface consumed by `parking_lot`. It serves as the stimulus source in system-level benches and as an on-board self-test driver for the detector.

## Interface
Parameters:
- `DWELL_W`, 8: width of the per-phase dwell count.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one car pass; sampled only in IDLE.
- `dir`  in  1  0 = entry, 1 = exit; latched with `start`.
- `dwell`  in  DWELL_W  cycles per phase; latched with `start`; 0 is treated as 1.
- `abort`  in  1  cancel the sequence in progress.
- `a`  out  1  outer beam sensor, registered.
- `b`  out  1  inner beam sensor, registered.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, PH1, PH2, PH3.
- Entry pattern `{a,b}`: IDLE 00 → PH1 10 → PH2 11 → PH3 01 → IDLE 00.
- Exit pattern: IDLE 00 → PH1 01 → PH2 11 → PH3 10 → IDLE 00.
- Normal transitions change exactly one of `a`/`b` (Gray sequence).
- IDLE with `start`=1: latch `dir` and `D = max(dwell,1)`, load the phase timer with D-1, go to PH1.
- PHn: hold the pattern while the timer is nonzero and decrement it each cycle. When the timer reads 0, advance to the next phase and reload D-1. PH3 advances to IDLE.
- PH3 → IDLE: `done`=1 for exactly the first IDLE cycle.
- `start` while busy: ignored, not queued.
- `start` during the `done` cycle: accepted, because the FSM is already in IDLE. A new PH1 follows directly, with 00 held for that one cycle only.
- `abort`=1 while busy: next edge goes to IDLE with `a`=`b`=0. No `done`. Both lines may drop together (models a car vanishing). `abort` takes priority over timer expiry.
- `abort` in IDLE: no effect. `start` in the same cycle is still accepted.
- `dir`/`dwell` changes while busy: ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `a`=0, `b`=0, `busy`=0, `done`=0, timer 0.
- Reset asserted mid-sequence: outputs go to 0 asynchronously. No `done`. After release, the block is IDLE.
- `start` sampled at edge k → PH1 pattern visible on cycles k+1 … k+D.
- PH2 on k+D+1 … k+2D; PH3 on k+2D+1 … k+3D.
- `a`=`b`=0 and `done`=1 in cycle k+3D+1.
- `busy` is high in cycles k+1 … k+3D, i.e. exactly 3·D cycles. It is registered and aligned with `a`/`b`.
- Maximum sequence: D = 2^DWELL_W − 1, giving 3·(2^DWELL_W − 1) busy cycles. The timer never wraps.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package `car_sensor_pkg`:
  - state encoding (IDLE, PH1, PH2, PH3);
  - pattern constants `ENTRY_PAT[1:3] = 10,11,01` and `EXIT_PAT[1:3] = 01,11,10`;
  - `DIR_ENTRY`/`DIR_EXIT`.
- One sub-module, `phase_timer`: loadable DWELL_W-bit down-counter with `load`, `val`, and `zero` flag, plus asynchronous active-low reset.
- Top level holds the FSM, the latched `dir`/D, and the output registers.

## Test plan
- Reset: assert `reset`=0 mid-PH2 of an entry → `a`,`b`,`busy`,`done` are 0 immediately; after release, a `start` works normally.
- Entry, `dwell`=2: `start`@k → `{a,b}` = 10,10,11,11,01,01 on k+1…k+6; 00 with `done`=1 on k+7; `busy` high for exactly 6 cycles.
- Exit, `dwell`=0 (treated as 1): `{a,b}` = 01,11,10 on k+1…k+3; `done` on k+4. Feeding `parking_lot` gives exactly one `exiting` pulse and no `entering` pulse.
- Back-to-back: `start` held high with `dwell`=1, `dir` alternating → entry, one 00/`done` cycle, then exit. The detector counts one entering and one exiting.
- `start` pulsed during PH2 with `dir` flipped → ignored; the original sequence and `dir` complete unchanged.
- `abort` in PH2 (11) of an entry with `dwell`=3 → next cycle is 00 and `busy`=0, no `done` pulse, and the detector reports no event.
